// File: rtl/cic_interp_pkg.sv
// Shared types and constants for the CIC interpolator blocks.
//   cic_rate_t       interpolation-factor type (CIC_RATE_W bits)
//   cic_zs_state_e   zero-stuffer FSM states
//   CIC_ZS_FIFO_DEPTH  zero-stuffer input FIFO depth (power of two)
package cic_interp_pkg;
  localparam int CIC_RATE_W        = 8;
  localparam int CIC_ZS_FIFO_DEPTH = 2;

  typedef logic [CIC_RATE_W-1:0] cic_rate_t;

  typedef enum logic {
    ZS_IDLE,
    ZS_RUN
  } cic_zs_state_e;
endpackage

// File: rtl/cic_zero_stuffer_if.sv
// I/Q sample bus around the zero stuffer.
//   i_inph_data/i_quad_data/i_valid/o_ready : input-rate stream (valid/ready)
//   o_inph_data/o_quad_data/o_valid         : output-rate stream (strobe only)
// slave  = the zero stuffer; master = upstream comb / downstream integrator side.
interface cic_zero_stuffer_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] i_inph_data;
  logic [WIDTH-1:0] i_quad_data;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_inph_data;
  logic [WIDTH-1:0] o_quad_data;
  logic             o_valid;

  modport slave (
    input  i_inph_data, i_quad_data, i_valid,
    output o_ready, o_inph_data, o_quad_data, o_valid
  );

  modport master (
    output i_inph_data, i_quad_data, i_valid,
    input  o_ready, o_inph_data, o_quad_data, o_valid
  );
endinterface

// File: rtl/cic_zs_fifo.sv
// Small I/Q input FIFO for the zero stuffer (CIC_ZS_FIFO_DEPTH entries).
//   i_clock, i_reset_n (async low), i_clear (sync flush)
//   i_push + i_inph/i_quad : write, caller guarantees !o_full
//   i_pop                  : read,  caller guarantees !o_empty
//   o_inph/o_quad          : head entry (valid while !o_empty)
//   o_full/o_empty         : occupancy flags from the registered count
module cic_zs_fifo
  import cic_interp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_inph,
  input  logic [WIDTH-1:0] i_quad,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_inph,
  output logic [WIDTH-1:0] o_quad,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(CIC_ZS_FIFO_DEPTH);

  logic [CIC_ZS_FIFO_DEPTH-1:0][2*WIDTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign o_full  = (count == (AW+1)'(CIC_ZS_FIFO_DEPTH));
  assign o_empty = (count == '0);
  assign {o_inph, o_quad} = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_push) begin
        mem[wr_ptr] <= {i_inph, i_quad};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (i_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
endmodule

// File: rtl/cic_zero_stuffer.sv
// CIC interpolator rate-expansion stage: per output tick (i_enable) emits one
// queued I/Q sample followed by R-1 zero slots; R latched from i_rate at each
// burst start (0 behaves as 1).
//   i_clock, i_reset_n (async low)
//   bus (slave)   : input valid/ready stream, output data + o_valid strobe
//   i_rate        : interpolation factor R
//   i_enable      : output-rate tick
//   i_clear       : sync flush of FIFO, phase, sticky flag; FSM -> idle
//   o_underflow   : sticky, burst start found the FIFO empty
// Build option CIC_ZS_HOLD_EN: non-sample slots repeat the last emitted value
// (zero-order hold) instead of zero.
module cic_zero_stuffer
  import cic_interp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int RATE_W = CIC_RATE_W
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  cic_zero_stuffer_if.slave bus,
  input  logic [RATE_W-1:0] i_rate,
  input  logic              i_enable,
  input  logic              i_clear,
  output logic              o_underflow
);
`ifdef CIC_ZS_HOLD_EN
  localparam bit ZERO_FILL = 1'b0;
`else
  localparam bit ZERO_FILL = 1'b1;
`endif

  cic_zs_state_e     state, state_nxt;
  logic [RATE_W-1:0] phase, phase_nxt;
  logic [RATE_W-1:0] rate_q, rate_nxt, rate_in;
  logic [WIDTH-1:0]  head_i, head_q, out_i, out_q;
  logic              fifo_full, fifo_empty, push, pop;
  logic              emit, take, uflow_set, out_vld;

  assign rate_in     = (i_rate == '0) ? RATE_W'(1) : i_rate;
  assign bus.o_ready = ~fifo_full;
  assign push        = bus.i_valid & ~fifo_full & ~i_clear;

  cic_zs_fifo #(.WIDTH(WIDTH)) u_fifo (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (i_clear),
    .i_push    (push),
    .i_inph    (bus.i_inph_data),
    .i_quad    (bus.i_quad_data),
    .i_pop     (pop),
    .o_inph    (head_i),
    .o_quad    (head_q),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= ZS_IDLE;
      phase  <= '0;
      rate_q <= RATE_W'(1);
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      rate_q <= rate_nxt;
    end
  end

  // Phase 0 starts a burst: the new R takes effect immediately so the next
  // phase is computed from it, not from the previous burst's R.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    rate_nxt  = rate_q;
    emit      = 1'b0;
    take      = 1'b0;
    pop       = 1'b0;
    uflow_set = 1'b0;
    if (i_clear) begin
      state_nxt = ZS_IDLE;
      phase_nxt = '0;
    end else if (i_enable) begin
      case (state)
        ZS_IDLE: begin
          if (!fifo_empty) begin
            state_nxt = ZS_RUN;
            emit      = 1'b1;
            take      = 1'b1;
            pop       = 1'b1;
            rate_nxt  = rate_in;
            phase_nxt = (rate_in == RATE_W'(1)) ? '0 : RATE_W'(1);
          end
        end
        ZS_RUN: begin
          emit = 1'b1;
          if (phase == '0) begin
            rate_nxt  = rate_in;
            phase_nxt = (rate_in == RATE_W'(1)) ? '0 : RATE_W'(1);
            if (!fifo_empty) begin
              take = 1'b1;
              pop  = 1'b1;
            end else begin
              // Grid keeps running; the slot is filled and flagged.
              uflow_set = 1'b1;
            end
          end else begin
            phase_nxt = (phase == rate_q - RATE_W'(1)) ? '0 : phase + RATE_W'(1);
          end
        end
        default: state_nxt = ZS_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_i       <= '0;
      out_q       <= '0;
      out_vld     <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      out_vld <= emit;
      if (i_clear)        o_underflow <= 1'b0;
      else if (uflow_set) o_underflow <= 1'b1;
      if (take) begin
        out_i <= head_i;
        out_q <= head_q;
      end else if (emit && ZERO_FILL) begin
        out_i <= '0;
        out_q <= '0;
      end
    end
  end

  assign bus.o_inph_data = out_i;
  assign bus.o_quad_data = out_q;
  assign bus.o_valid     = out_vld;
endmodule

// File: tb/tb_cic_zero_stuffer.sv
module tb_cic_zero_stuffer;
  import cic_interp_pkg::*;
  localparam int WIDTH  = 16;
  localparam int RATE_W = 8;
`ifdef CIC_ZS_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic              i_clock = 1'b0;
  logic              i_reset_n = 1'b0;
  logic [RATE_W-1:0] i_rate = '0;
  logic              i_enable = 1'b0;
  logic              i_clear = 1'b0;
  logic              o_underflow;

  cic_zero_stuffer_if #(.WIDTH(WIDTH)) bus();

  cic_zero_stuffer #(.WIDTH(WIDTH), .RATE_W(RATE_W)) dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .bus         (bus.slave),
    .i_rate      (i_rate),
    .i_enable    (i_enable),
    .i_clear     (i_clear),
    .o_underflow (o_underflow)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: output stream is a series of bursts of R ticks; each
  // burst opens with the oldest queued sample (or a flagged filler when none
  // is queued) and is padded by R-1 fillers.
  typedef struct {
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] q;
  } smp_t;

  smp_t             mq[$];
  bit               m_run;
  int               m_left;   // filler ticks still owed in the current burst
  logic             m_vld, m_uf;
  logic [WIDTH-1:0] m_i, m_q;

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_left = 0; m_vld = 0; m_uf = 0; m_i = '0; m_q = '0;
  endtask

  task automatic compare_all();
    chk("o_valid", 32'(bus.o_valid), 32'(m_vld));
    chk("o_inph", 32'(bus.o_inph_data), 32'(m_i));
    chk("o_quad", 32'(bus.o_quad_data), 32'(m_q));
    chk("o_ready", 32'(bus.o_ready), 32'(mq.size() < 2));
    chk("o_underflow", 32'(o_underflow), 32'(m_uf));
  endtask

  task automatic step();
    bit   can_push;
    smp_t s;
    int   r;
    @(posedge i_clock);
    can_push = (mq.size() < 2);
    m_vld = 0;
    if (i_clear) begin
      mq.delete();
      m_run = 0; m_left = 0; m_uf = 0;
    end else begin
      if (i_enable && (m_run || mq.size() > 0)) begin
        m_vld = 1;
        if (m_left == 0) begin
          r = (i_rate == 0) ? 1 : int'(i_rate);
          m_left = r - 1;
          m_run = 1;
          if (mq.size() > 0) begin
            s = mq.pop_front();
            m_i = s.i; m_q = s.q;
          end else begin
            m_uf = 1;
            if (!HOLD) begin m_i = '0; m_q = '0; end
          end
        end else begin
          m_left--;
          if (!HOLD) begin m_i = '0; m_q = '0; end
        end
      end
      if (bus.i_valid && can_push) begin
        s.i = bus.i_inph_data; s.q = bus.i_quad_data;
        mq.push_back(s);
      end
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] dq);
    bus.i_valid = v; bus.i_inph_data = di; bus.i_quad_data = dq;
  endtask

  task automatic do_clear();
    i_clear = 1'b1; step(); i_clear = 1'b0;
  endtask

  int nxt;

  initial begin
    drive(1'b0, '0, '0);
    model_reset();
    #1;
    compare_all();
    #11 i_reset_n = 1'b1;

    // R=4, continuous ticks, two samples.
    i_rate = 8'd4; i_enable = 1'b1;
    drive(1'b1, 16'd100, -16'sd100); step();
    drive(1'b1, 16'd7, 16'd8);       step();
    drive(1'b0, '0, '0);
    repeat (9) step();
    do_clear();

    // R=1, tick every third cycle, samples 1..5.
    i_rate = 8'd1; nxt = 1;
    for (int c = 0; c < 24; c++) begin
      i_enable = (c % 3 == 0);
      if (nxt <= 5) drive(1'b1, 16'(nxt), 16'(nxt + 16)); else drive(1'b0, '0, '0);
      if (nxt <= 5 && mq.size() < 2) nxt++;
      step();
    end
    do_clear();

    // R=3, single sample then starvation, then clear.
    i_rate = 8'd3; i_enable = 1'b1;
    drive(1'b1, 16'd9, 16'd9); step();
    drive(1'b0, '0, '0);
    repeat (6) step();
    do_clear();
    step();

    // R=8, upstream valid held: FIFO fills and backpressures.
    i_rate = 8'd8;
    for (int c = 0; c < 10; c++) begin drive(1'b1, 16'(c + 40), 16'(c + 80)); step(); end
    drive(1'b0, '0, '0);
    repeat (12) step();
    do_clear();

    // Rate change mid-burst (4 -> 2 at phase 2), then rate 0.
    i_rate = 8'd4;
    drive(1'b1, 16'd11, 16'd12); step();
    drive(1'b1, 16'd13, 16'd14); step();
    drive(1'b0, '0, '0); step();
    i_rate = 8'd2;
    repeat (5) step();
    i_rate = 8'd0;
    drive(1'b1, 16'd21, 16'd22); step();
    drive(1'b1, 16'd23, 16'd24); step();
    drive(1'b0, '0, '0);
    repeat (4) step();
    do_clear();

    // Async reset in the middle of an R=4 burst.
    i_rate = 8'd4;
    drive(1'b1, 16'd55, 16'd66); step();
    drive(1'b0, '0, '0);
    repeat (3) step();
    i_reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 i_reset_n = 1'b1;
    repeat (3) step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) i_rate = 8'($urandom_range(0, 5));
      i_enable = ($urandom_range(0, 3) != 0);
      i_clear  = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom));
      step();
    end
    i_clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
